// File: rtl/ame_num_approx_pkg.sv
// Shared constants and helpers for the AME multi-lane log2 approximator.
package ame_num_approx_pkg;

    localparam int GRP_BITS = 8;

    // Exponent width: leading-one index plus one bit so a rounded result can reach W.
    function automatic int exp_bits(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/ame_num_approx_pipe_lod.sv
// Combinational W-bit leading-one detector (8-bit group priority + group encoder).
// The round-bit output exists only when AME_NUM_APPROX_ROUND_EN is defined.
module ame_lod_w
    import ame_num_approx_pkg::*;
#(
    parameter  int DATA_BITS = 64,
    localparam int POS_BITS  = $clog2(DATA_BITS),
    localparam int NGRP      = DATA_BITS / GRP_BITS
) (
    input  logic [DATA_BITS-1:0] data_i,
    input  logic [NGRP-1:0]      grp_or_i,
    output logic [POS_BITS-1:0]  pos_o,
`ifdef AME_NUM_APPROX_ROUND_EN
    output logic                 rnd_o,
`endif
    output logic                 zero_o
);

    localparam int BIDX_BITS = $clog2(GRP_BITS);
    localparam int GIDX_BITS = POS_BITS - BIDX_BITS;

    logic [GIDX_BITS-1:0] grp_idx;
    logic [GRP_BITS-1:0]  grp_byte;
    logic [BIDX_BITS-1:0] bit_idx;

    always_comb begin
        grp_idx = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (grp_or_i[g]) grp_idx = GIDX_BITS'(g);
        end
    end

    assign grp_byte = data_i[grp_idx*GRP_BITS +: GRP_BITS];

    always_comb begin
        bit_idx = '0;
        for (int b = 0; b < GRP_BITS; b++) begin
            if (grp_byte[b]) bit_idx = BIDX_BITS'(b);
        end
    end

    assign pos_o  = {grp_idx, bit_idx};
    assign zero_o = ~|grp_or_i;

`ifdef AME_NUM_APPROX_ROUND_EN
    // The bit just below the leading one decides whether |x| is past 1.5*2^p.
    assign rnd_o = (pos_o != '0) && data_i[pos_o - 1'b1];
`endif

endmodule

// File: rtl/ame_num_approx_pipe.sv
// AME multi-lane log2 approximator: two register stages with valid/ready and full backpressure.
// Define AME_NUM_APPROX_ROUND_EN for round-to-nearest exponents; otherwise floor(log2|x|).
module ame_num_approx_pipe
    import ame_num_approx_pkg::*;
#(
    parameter  int DATA_BITS = 64,
    parameter  int LANES     = 4,
    localparam int EXP_BITS  = exp_bits(DATA_BITS)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_signed_i,
    input  logic [LANES*DATA_BITS-1:0] in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*EXP_BITS-1:0] out_exp_o,
    output logic [LANES-1:0]          out_sign_o,
    output logic [LANES-1:0]          out_zero_o
);

    localparam int POS_BITS = EXP_BITS - 1;
    localparam int NGRP     = DATA_BITS / GRP_BITS;

    logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic s1_adv, s2_adv;

    logic [LANES-1:0][DATA_BITS-1:0] abs_d, abs_q;
    logic [LANES-1:0][NGRP-1:0]      grp_d, grp_q;
    logic [LANES-1:0]                sign_d, s1_sign_q, s2_sign_q;
    logic [LANES-1:0][POS_BITS-1:0]  pos_d, pos_q;
    logic [LANES-1:0]                zero_d, zero_q;
`ifdef AME_NUM_APPROX_ROUND_EN
    logic [LANES-1:0]                rnd_d, rnd_q;
`endif

    assign s2_adv     = !s2_v_q || out_ready_i;
    assign s1_adv     = !s1_v_q || s2_adv;
    assign in_ready_o = s1_adv;

    assign s1_v_d = s1_adv ? in_valid_i : s1_v_q;
    assign s2_v_d = s2_adv ? s1_v_q : s2_v_q;

    // Two's-complement negate keeps -2^(W-1) as 2^(W-1) in W unsigned bits.
    always_comb begin
        sign_d = '0;
        abs_d  = '0;
        grp_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            sign_d[k] = in_signed_i & in_data_i[k*DATA_BITS + DATA_BITS - 1];
            abs_d[k]  = sign_d[k] ? (~in_data_i[k*DATA_BITS +: DATA_BITS] + 1'b1)
                                  : in_data_i[k*DATA_BITS +: DATA_BITS];
            for (int g = 0; g < NGRP; g++) begin
                grp_d[k][g] = |abs_d[k][g*GRP_BITS +: GRP_BITS];
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ame_lod_w #(.DATA_BITS(DATA_BITS)) u_lod (
            .data_i   (abs_q[k]),
            .grp_or_i (grp_q[k]),
            .pos_o    (pos_d[k]),
`ifdef AME_NUM_APPROX_ROUND_EN
            .rnd_o    (rnd_d[k]),
`endif
            .zero_o   (zero_d[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            abs_q     <= '0;
            grp_q     <= '0;
            s1_sign_q <= '0;
            s2_sign_q <= '0;
            pos_q     <= '0;
            zero_q    <= '0;
`ifdef AME_NUM_APPROX_ROUND_EN
            rnd_q     <= '0;
`endif
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            if (in_valid_i && s1_adv) begin
                abs_q     <= abs_d;
                grp_q     <= grp_d;
                s1_sign_q <= sign_d;
            end
            if (s1_v_q && s2_adv) begin
                pos_q     <= pos_d;
                zero_q    <= zero_d;
                s2_sign_q <= s1_sign_q;
`ifdef AME_NUM_APPROX_ROUND_EN
                rnd_q     <= rnd_d;
`endif
            end
        end
    end

    always_comb begin
        out_exp_o = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef AME_NUM_APPROX_ROUND_EN
            out_exp_o[k*EXP_BITS +: EXP_BITS] = {1'b0, pos_q[k]} + EXP_BITS'(rnd_q[k]);
`else
            out_exp_o[k*EXP_BITS +: EXP_BITS] = {1'b0, pos_q[k]};
`endif
        end
    end

    assign out_valid_o = s2_v_q;
    assign out_sign_o  = s2_sign_q;
    assign out_zero_o  = zero_q;

endmodule
